// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the multicycle MIPS controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch    = 4'd0;
    localparam state_t c_st_decode   = 4'd1;
    localparam state_t c_st_rtype_ex = 4'd2;
    localparam state_t c_st_rtype_wb = 4'd3;
    localparam state_t c_st_imm_ex   = 4'd4;
    localparam state_t c_st_imm_wb   = 4'd5;
    localparam state_t c_st_mem_addr = 4'd6;
    localparam state_t c_st_mem_rd   = 4'd7;
    localparam state_t c_st_mem_wb   = 4'd8;
    localparam state_t c_st_mem_wr   = 4'd9;
    localparam state_t c_st_branch   = 4'd10;
    localparam state_t c_st_jr       = 4'd11;
    localparam state_t c_st_jump     = 4'd12;
    localparam state_t c_st_jal      = 4'd13;
    localparam state_t c_st_fault    = 4'd14;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_xori  = 6'h0E;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00;
    localparam logic [5:0] c_fn_srl  = 6'h02;
    localparam logic [5:0] c_fn_sra  = 6'h03;
    localparam logic [5:0] c_fn_jr   = 6'h08;
    localparam logic [5:0] c_fn_add  = 6'h20;
    localparam logic [5:0] c_fn_addu = 6'h21;
    localparam logic [5:0] c_fn_sub  = 6'h22;
    localparam logic [5:0] c_fn_subu = 6'h23;
    localparam logic [5:0] c_fn_and  = 6'h24;
    localparam logic [5:0] c_fn_or   = 6'h25;
    localparam logic [5:0] c_fn_xor  = 6'h26;
    localparam logic [5:0] c_fn_nor  = 6'h27;
    localparam logic [5:0] c_fn_slt  = 6'h2A;

    localparam logic [3:0] c_alu_and = 4'd0;
    localparam logic [3:0] c_alu_or  = 4'd1;
    localparam logic [3:0] c_alu_add = 4'd2;
    localparam logic [3:0] c_alu_xor = 4'd3;
    localparam logic [3:0] c_alu_nor = 4'd4;
    localparam logic [3:0] c_alu_sub = 4'd6;
    localparam logic [3:0] c_alu_slt = 4'd7;
    localparam logic [3:0] c_alu_sll = 4'd8;
    localparam logic [3:0] c_alu_srl = 4'd9;
    localparam logic [3:0] c_alu_sra = 4'd10;

    localparam logic [1:0] c_srca_pc     = 2'b00;
    localparam logic [1:0] c_srca_a      = 2'b01;
    localparam logic [1:0] c_srca_shamt  = 2'b10;
    localparam logic [1:0] c_srcb_b      = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_bra    = 2'b11;
    localparam logic [1:0] c_m2r_mem     = 2'b01;
    localparam logic [1:0] c_m2r_pc      = 2'b10;
    localparam logic [1:0] c_rdst_rt     = 2'b00;
    localparam logic [1:0] c_rdst_rd     = 2'b01;
    localparam logic [1:0] c_rdst_r31    = 2'b10;
    localparam logic [1:0] c_pcs_aluout  = 2'b01;
    localparam logic [1:0] c_pcs_jump    = 2'b10;
    localparam logic [1:0] c_pcs_a       = 2'b11;

    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_fetch   = 2'b10;
    localparam logic [1:0] c_cause_data    = 2'b11;

    function automatic logic funct_is_alu(input logic [5:0] f);
        case (f)
            c_fn_sll, c_fn_srl, c_fn_sra, c_fn_add, c_fn_addu, c_fn_sub, c_fn_subu,
            c_fn_and, c_fn_or, c_fn_xor, c_fn_nor, c_fn_slt: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_for_funct(input logic [5:0] f);
        case (f)
            c_fn_sub, c_fn_subu: return c_alu_sub;
            c_fn_and:            return c_alu_and;
            c_fn_or:             return c_alu_or;
            c_fn_xor:            return c_alu_xor;
            c_fn_nor:            return c_alu_nor;
            c_fn_slt:            return c_alu_slt;
            c_fn_sll:            return c_alu_sll;
            c_fn_srl:            return c_alu_srl;
            c_fn_sra:            return c_alu_sra;
            default:             return c_alu_add;
        endcase
    endfunction

    function automatic logic [3:0] alu_for_imm(input logic [5:0] op);
        case (op)
            c_op_slti: return c_alu_slt;
            c_op_andi: return c_alu_and;
            c_op_ori:  return c_alu_or;
            c_op_xori: return c_alu_xor;
            default:   return c_alu_add;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module      : mc_wait_timer
// Description : Saturating memory-wait counter; expired when it hits the limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            localparam logic [CW-1:0] c_limit = CW'(MEM_TIMEOUT);

            logic [CW-1:0] r_count_q;
            logic [CW-1:0] w_count_d;

            // Clear wins over tick so a state change always restarts the wait
            always_comb begin
                w_count_d = r_count_q;
                if (clear) begin
                    w_count_d = '0;
                end else if (tick && !expired) begin
                    w_count_d = r_count_q + CW'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count_q <= '0;
                end else begin
                    r_count_q <= w_count_d;
                end
            end

            assign expired = (r_count_q == c_limit);
        end else begin : g_tie_off
            logic w_unused;
            assign w_unused = clk ^ rst ^ clear ^ tick;
            assign expired  = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_hs.sv
// ============================================================================
// Module      : mc_ctrl_hs
// Description : Multicycle MIPS control FSM with mem_ready handshake and timeout trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_hs
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Branch,
    output logic       BranchType,
    output logic       ZeroExt,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [3:0] ALUControl,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam state_t c_illegal_dest = (TRAP_ILLEGAL != 0) ? c_st_fault : c_st_fetch;

    state_t     r_state_q, w_state_d;
    logic [1:0] r_cause_q, w_cause_d;
    logic       w_ready, w_in_wait, w_expired, w_tick, w_clear;

    // A ready seen while clk_en is low is not a completed handshake
    assign w_ready   = mem_ready & clk_en;
    assign w_in_wait = (r_state_q == c_st_fetch) || (r_state_q == c_st_mem_rd) ||
                       (r_state_q == c_st_mem_wr);
    assign w_tick    = clk_en & w_in_wait & ~mem_ready;
    assign w_clear   = clk_en & (w_state_d != r_state_q);

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .tick    (w_tick),
        .expired (w_expired)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_cause_d = r_cause_q;
        if (clk_en) begin
            case (r_state_q)
                c_st_fetch: begin
                    if (mem_ready) begin
                        w_state_d = c_st_decode;
                    end else if (w_expired) begin
                        w_state_d = c_st_fault;
                        w_cause_d = c_cause_fetch;
                    end
                end
                c_st_decode: begin
                    case (opcode)
                        c_op_rtype: begin
                            if (funct == c_fn_jr) begin
                                w_state_d = c_st_jr;
                            end else if (funct_is_alu(funct)) begin
                                w_state_d = c_st_rtype_ex;
                            end else begin
                                w_state_d = c_illegal_dest;
                                if (TRAP_ILLEGAL != 0) w_cause_d = c_cause_illegal;
                            end
                        end
                        c_op_addi, c_op_slti, c_op_andi, c_op_ori, c_op_xori:
                            w_state_d = c_st_imm_ex;
                        c_op_lw, c_op_sw:   w_state_d = c_st_mem_addr;
                        c_op_beq, c_op_bne: w_state_d = c_st_branch;
                        c_op_j:             w_state_d = c_st_jump;
                        c_op_jal:           w_state_d = c_st_jal;
                        default: begin
                            w_state_d = c_illegal_dest;
                            if (TRAP_ILLEGAL != 0) w_cause_d = c_cause_illegal;
                        end
                    endcase
                end
                c_st_rtype_ex: w_state_d = c_st_rtype_wb;
                c_st_imm_ex:   w_state_d = c_st_imm_wb;
                c_st_mem_addr: w_state_d = (opcode == c_op_sw) ? c_st_mem_wr : c_st_mem_rd;
                c_st_mem_rd, c_st_mem_wr: begin
                    if (mem_ready) begin
                        w_state_d = (r_state_q == c_st_mem_rd) ? c_st_mem_wb : c_st_fetch;
                    end else if (w_expired) begin
                        w_state_d = c_st_fault;
                        w_cause_d = c_cause_data;
                    end
                end
                c_st_fault: w_state_d = c_st_fault;
                default:    w_state_d = c_st_fetch;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= c_st_fetch;
            r_cause_q <= c_cause_none;
        end else begin
            r_state_q <= w_state_d;
            r_cause_q <= w_cause_d;
        end
    end

    assign fault       = (r_state_q == c_st_fault);
    assign fault_cause = r_cause_q;

    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Branch     = 1'b0;
        BranchType = 1'b0;
        ZeroExt    = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        ALUControl = c_alu_add;
        case (r_state_q)
            c_st_fetch: begin
                mem_req = 1'b1;
                ALUSrcB = c_srcb_four;
                IRWrite = w_ready;
                PCWrite = w_ready;
            end
            c_st_decode: ALUSrcB = c_srcb_bra;
            c_st_rtype_ex: begin
                ALUSrcA    = ((funct == c_fn_sll) || (funct == c_fn_srl) || (funct == c_fn_sra))
                             ? c_srca_shamt : c_srca_a;
                ALUSrcB    = c_srcb_b;
                ALUControl = alu_for_funct(funct);
            end
            c_st_rtype_wb: begin
                RegDst   = c_rdst_rd;
                RegWrite = 1'b1;
            end
            c_st_imm_ex: begin
                ALUSrcA    = c_srca_a;
                ALUSrcB    = c_srcb_imm;
                ALUControl = alu_for_imm(opcode);
                ZeroExt    = (opcode == c_op_andi) || (opcode == c_op_ori) || (opcode == c_op_xori);
            end
            c_st_imm_wb: begin
                RegDst   = c_rdst_rt;
                RegWrite = 1'b1;
            end
            c_st_mem_addr: begin
                ALUSrcA = c_srca_a;
                ALUSrcB = c_srcb_imm;
            end
            c_st_mem_rd: begin
                IorD    = 1'b1;
                mem_req = 1'b1;
            end
            c_st_mem_wb: begin
                MemtoReg = c_m2r_mem;
                RegWrite = 1'b1;
            end
            c_st_mem_wr: begin
                IorD     = 1'b1;
                mem_req  = 1'b1;
                MemWrite = 1'b1;
            end
            c_st_branch: begin
                ALUSrcA    = c_srca_a;
                ALUSrcB    = c_srcb_b;
                ALUControl = c_alu_sub;
                Branch     = 1'b1;
                PCSrc      = c_pcs_aluout;
                BranchType = (opcode == c_op_beq);
            end
            c_st_jr: begin
                PCSrc   = c_pcs_a;
                PCWrite = 1'b1;
            end
            c_st_jump: begin
                PCSrc   = c_pcs_jump;
                PCWrite = 1'b1;
            end
            c_st_jal: begin
                RegDst   = c_rdst_r31;
                MemtoReg = c_m2r_pc;
                RegWrite = 1'b1;
                PCSrc    = c_pcs_jump;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_hs.sv
// ============================================================================
// Module      : tb_mc_ctrl_hs
// Description : Random-stimulus bench for mc_ctrl_hs against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_hs;
    import cpu_pkg::*;

    typedef enum {M_FETCH, M_DECODE, M_REX, M_RWB, M_IEX, M_IWB, M_MADDR, M_MRD,
                  M_MWB, M_MWR, M_BR, M_JR, M_J, M_JAL, M_FAULT} mstate_t;

    logic       clk = 1'b0;
    logic       rst, clk_en, mem_ready;
    logic [5:0] opcode [2];
    logic [5:0] funct  [2];
    logic [1:0] mem_req, IorD, IRWrite, PCWrite, RegWrite, MemWrite, Branch, BranchType, ZeroExt, fault;
    logic [1:0] ALUSrcA [2], ALUSrcB [2], PCSrc [2], RegDst [2], MemtoReg [2], fault_cause [2];
    logic [3:0] ALUControl [2];

    always #5 clk = ~clk;

    // Instance 0: timeout 4 with trapping; instance 1: timeout disabled, illegal as NOP
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mc_ctrl_hs #(.MEM_TIMEOUT(g == 0 ? 4 : 0), .TRAP_ILLEGAL(g == 0 ? 1 : 0)) u_dut (
            .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode[g]), .funct(funct[g]),
            .mem_ready(mem_ready), .mem_req(mem_req[g]), .IorD(IorD[g]), .IRWrite(IRWrite[g]),
            .PCWrite(PCWrite[g]), .RegWrite(RegWrite[g]), .MemWrite(MemWrite[g]),
            .Branch(Branch[g]), .BranchType(BranchType[g]), .ZeroExt(ZeroExt[g]),
            .ALUSrcA(ALUSrcA[g]), .ALUSrcB(ALUSrcB[g]), .PCSrc(PCSrc[g]), .RegDst(RegDst[g]),
            .MemtoReg(MemtoReg[g]), .ALUControl(ALUControl[g]), .fault(fault[g]),
            .fault_cause(fault_cause[g])
        );
    end

    int         n_chk = 0;
    int         n_fail = 0;
    int         p_ready;
    mstate_t    m_st [2];
    int         m_cnt [2];
    logic [1:0] m_cause [2];
    bit         new_instr [2];
    logic [5:0] ins_op [25];
    logic [5:0] ins_fn [25];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic bit r_known(input logic [5:0] fn);
        return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                          6'h00, 6'h02, 6'h03};
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22, 6'h23: return c_alu_sub;
            6'h24: return c_alu_and;
            6'h25: return c_alu_or;
            6'h26: return c_alu_xor;
            6'h27: return c_alu_nor;
            6'h2A: return c_alu_slt;
            6'h00: return c_alu_sll;
            6'h02: return c_alu_srl;
            6'h03: return c_alu_sra;
            default: return c_alu_add;
        endcase
    endfunction

    // Packed observation: {mem_req,IorD,IRWrite,PCWrite,RegWrite,MemWrite,Branch,BranchType,ZeroExt,A,B,PCSrc,RegDst,MemtoReg,ALU}
    function automatic logic [22:0] obs(input int k);
        return {mem_req[k], IorD[k], IRWrite[k], PCWrite[k], RegWrite[k], MemWrite[k], Branch[k],
                BranchType[k], ZeroExt[k], ALUSrcA[k], ALUSrcB[k], PCSrc[k], RegDst[k],
                MemtoReg[k], ALUControl[k]};
    endfunction

    function automatic logic [22:0] exp_out(input mstate_t s, input logic [5:0] op,
                                            input logic [5:0] fn, input logic rdy, input logic en);
        logic mq, io, ir, pw, rw, mw, br, bt, ze;
        logic [1:0] sa, sb, ps, rd, mr;
        logic [3:0] alu;
        {mq, io, ir, pw, rw, mw, br, bt, ze} = '0;
        {sa, sb, ps, rd, mr} = '0;
        alu = c_alu_add;
        case (s)
            M_FETCH:  begin mq = 1; sb = 2'b01; ir = rdy & en; pw = rdy & en; end
            M_DECODE: sb = 2'b11;
            M_REX:    begin sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01; alu = r_alu(fn); end
            M_RWB:    begin rd = 2'b01; rw = 1; end
            M_IEX: begin
                sa = 2'b01; sb = 2'b10;
                ze = (op == 6'h0C || op == 6'h0D || op == 6'h0E);
                alu = (op == 6'h0A) ? c_alu_slt : (op == 6'h0C) ? c_alu_and :
                      (op == 6'h0D) ? c_alu_or : (op == 6'h0E) ? c_alu_xor : c_alu_add;
            end
            M_IWB:    rw = 1;
            M_MADDR:  begin sa = 2'b01; sb = 2'b10; end
            M_MRD:    begin io = 1; mq = 1; end
            M_MWB:    begin mr = 2'b01; rw = 1; end
            M_MWR:    begin io = 1; mq = 1; mw = 1; end
            M_BR:     begin sa = 2'b01; alu = c_alu_sub; br = 1; ps = 2'b01; bt = (op == 6'h04); end
            M_JR:     begin ps = 2'b11; pw = 1; end
            M_J:      begin ps = 2'b10; pw = 1; end
            M_JAL:    begin rd = 2'b10; mr = 2'b10; rw = 1; ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {mq, io, ir, pw, rw, mw, br, bt, ze, sa, sb, ps, rd, mr, alu};
    endfunction

    task automatic model_reset(input int k);
        m_st[k] = M_FETCH;
        m_cnt[k] = 0;
        m_cause[k] = 2'b00;
    endtask

    task automatic model_step(input int k);
        mstate_t nxt;
        logic [5:0] op, fn;
        bit ill;
        nxt = m_st[k];
        op = opcode[k];
        fn = funct[k];
        ill = 0;
        new_instr[k] = 0;
        if (!clk_en) return;
        case (m_st[k])
            M_FETCH, M_MRD, M_MWR: begin
                if (mem_ready) begin
                    nxt = (m_st[k] == M_FETCH) ? M_DECODE : (m_st[k] == M_MRD) ? M_MWB : M_FETCH;
                    new_instr[k] = (m_st[k] == M_FETCH);
                end else if (to_of(k) != 0 && m_cnt[k] == to_of(k)) begin
                    nxt = M_FAULT;
                    m_cause[k] = (m_st[k] == M_FETCH) ? 2'b10 : 2'b11;
                end else begin
                    m_cnt[k]++;
                end
            end
            M_DECODE: begin
                case (op)
                    6'h00: if (fn == 6'h08) nxt = M_JR; else if (r_known(fn)) nxt = M_REX; else ill = 1;
                    6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: nxt = M_IEX;
                    6'h23, 6'h2B: nxt = M_MADDR;
                    6'h04, 6'h05: nxt = M_BR;
                    6'h02: nxt = M_J;
                    6'h03: nxt = M_JAL;
                    default: ill = 1;
                endcase
                if (ill && k == 0) begin nxt = M_FAULT; m_cause[k] = 2'b01; end
                else if (ill) nxt = M_FETCH;
            end
            M_REX:   nxt = M_RWB;
            M_IEX:   nxt = M_IWB;
            M_MADDR: nxt = (op == 6'h2B) ? M_MWR : M_MRD;
            M_FAULT: nxt = M_FAULT;
            default: nxt = M_FETCH;
        endcase
        if (nxt != m_st[k]) m_cnt[k] = 0;
        m_st[k] = nxt;
    endtask

    task automatic load_instr(input int k);
        int i;
        i = $urandom_range(24);
        opcode[k] = ins_op[i];
        funct[k]  = (ins_op[i] == 6'h00) ? ins_fn[i] : 6'($urandom);
    endtask

    function automatic int pick_p();
        case ($urandom_range(3))
            0: return 100;
            1: return 70;
            2: return 30;
            default: return 5;
        endcase
    endfunction

    initial begin
        ins_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                   6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05,
                   6'h02, 6'h03, 6'h3F};
        ins_fn = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03,
                   6'h08, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                   6'h00, 6'h00, 6'h00};
        rst = 1'b1;
        clk_en = 1'b0;
        mem_ready = 1'b0;
        p_ready = 100;
        for (int k = 0; k < 2; k++) begin
            load_instr(k);
            model_reset(k);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_outs%0d", k), 32'(obs(k)), 32'(exp_out(M_FETCH, opcode[k], funct[k], 1'b0, 1'b0)));
            chk($sformatf("reset_fault%0d", k), {29'd0, fault[k], fault_cause[k]}, 32'd0);
        end

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
            #1;
            for (int k = 0; k < 2; k++) if (new_instr[k]) load_instr(k);
            clk_en    = ($urandom_range(99) < 85);
            mem_ready = ($urandom_range(99) < p_ready);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("outs%0d", k), 32'(obs(k)),
                    32'(exp_out(m_st[k], opcode[k], funct[k], mem_ready, clk_en)));
                chk($sformatf("fault%0d", k), {29'd0, fault[k], fault_cause[k]},
                    {29'd0, (m_st[k] == M_FAULT), m_cause[k]});
            end
            // Asynchronous reset pulse between clock edges
            if ($urandom_range(99) < 3) begin
                rst = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("rst_memreq_fault%0d", k), {29'd0, mem_req[k], fault[k], fault_cause[k]},
                        {29'd0, 1'b1, 1'b0, 2'b00});
                    chk($sformatf("rst_outs%0d", k), 32'(obs(k)),
                        32'(exp_out(M_FETCH, opcode[k], funct[k], mem_ready, clk_en)));
                    model_reset(k);
                end
                p_ready = pick_p();
                #1 rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
